byte_packer: RTL and testbench

Downstream stage of the byte FIFO's valid/ready read port. Accepts a stream of 8-bit bytes and packs `BYTES` consecutive bytes little-endian into one word on a valid/ready output. A `flush` pulse emits a partial word with a byte-keep mask. A single output register decouples the two handshakes and sustains one byte per cycle when the consumer is always ready.

---
 rtl/byte_packer_pkg.sv | 18 +
 rtl/pack_out_slot.sv | 54 +++++
 rtl/byte_packer.sv | 130 +++++++++++++
 tb/tb_byte_packer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/byte_packer_pkg.sv
// Shared types and helpers for the byte packer: FSM state encoding,
// byte width and the partial-word keep mask.
package byte_packer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Mask with the low cnt bits set; cnt == 8 wraps to all ones.
    function automatic logic [7:0] keep_for_count(input logic [3:0] cnt);
        return (8'd1 << cnt) - 8'd1;
    endfunction

endpackage

// File: rtl/pack_out_slot.sv
// Single-entry output register with valid flag; a load may coincide with
// a drain so the slot can turn over one word per cycle.
module pack_out_slot #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              out_ready,
    output logic              slot_free,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEEP_W-1:0] keep_q, keep_d;

    assign slot_free = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            keep_d  = load_keep;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;

endmodule

// File: rtl/byte_packer.sv
// Packs BYTES consecutive input bytes little-endian into one output word;
// a flush pulse emits the partial word with a byte-keep mask.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W-1:0]       in_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W*BYTES-1:0] out_data,
    output logic [BYTES-1:0]        out_keep
);

    localparam int WORD_W = BYTE_W * BYTES;

    state_t            state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic [WORD_W-1:0] acc_q, acc_d;

    logic              in_fire;
    logic              slot_free;
    logic              load;
    logic [WORD_W-1:0] load_data;
    logic [BYTES-1:0]  load_keep;
    logic [WORD_W-1:0] acc_new;
    logic [3:0]        cnt_new;

    // in_ready looks only at registered state, never at out_ready.
    assign in_ready = !rst && (state_q == FILL);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        load      = 1'b0;
        load_data = acc_q;
        load_keep = '0;
        acc_new   = acc_q;
        cnt_new   = count_q;
        unique case (state_q)
            FILL: begin
                if (in_fire) begin
                    acc_new = acc_q | (WORD_W'(in_data) << {count_q, 3'b000});
                    cnt_new = count_q + 4'd1;
                end
                if (in_fire && count_q == 4'(BYTES - 1)) begin
                    // A completed word absorbs any flush in the same cycle.
                    if (slot_free) begin
                        load      = 1'b1;
                        load_data = acc_new;
                        load_keep = '1;
                        acc_d     = '0;
                        count_d   = 4'd0;
                    end else begin
                        acc_d   = acc_new;
                        count_d = 4'(BYTES);
                        state_d = FULL;
                    end
                end else begin
                    acc_d   = acc_new;
                    count_d = cnt_new;
                    if (flush && cnt_new != 4'd0) begin
                        state_d = FLUSH;
                    end
                end
            end
            FULL: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = acc_q;
                    load_keep = '1;
                    acc_d     = '0;
                    count_d   = 4'd0;
                    state_d   = FILL;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = acc_q;
                    load_keep = BYTES'(keep_for_count(count_q));
                    acc_d     = '0;
                    count_d   = 4'd0;
                    state_d   = FILL;
                end
            end
            default: begin
                state_d = FILL;
                acc_d   = '0;
                count_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= 4'd0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    pack_out_slot #(
        .DATA_W (WORD_W),
        .KEEP_W (BYTES)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .out_ready (out_ready),
        .slot_free (slot_free),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep)
    );

endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer with BYTES = 4: streaming, flush,
// back-pressure, flush on the last byte and mid-word reset.
module tb_byte_packer;

    localparam int BYTES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;

    int checks = 0;
    int errors = 0;

    logic [35:0] mon_q[$];

    always #5 clk = ~clk;

    byte_packer #(.BYTES(BYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep)
    );

    // Records every word the consumer takes as {keep, data}.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) mon_q.push_back({out_keep, out_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        checks++; if (out_keep !== 4'h0) begin errors++; $display("FAIL reset_out_keep: got %h expected 0", out_keep); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        mon_q.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready byte %0d: got %b expected 1", i, in_ready); end
            tick();
            if (i == 4) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin
                    errors++; $display("FAIL b2b_latency: got valid %b data %h expected 1 04030201", out_valid, out_data); end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (mon_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", mon_q.size()); end
        if (mon_q.size() == 2) begin
            checks++; if (mon_q[0] !== 36'hF_04030201) begin errors++; $display("FAIL b2b_word0: got %h expected F04030201", mon_q[0]); end
            checks++; if (mon_q[1] !== 36'hF_08070605) begin errors++; $display("FAIL b2b_word1: got %h expected F08070605", mon_q[1]); end
        end
    endtask

    task automatic test_flush();
        mon_q.delete();
        out_ready = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready_low: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_early_valid: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h00332211 || out_keep !== 4'h7) begin
            errors++; $display("FAIL flush_word: got %b %h %h expected 1 00332211 7", out_valid, out_data, out_keep); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_resume: got %b expected 1", in_ready); end
        tick();
        checks++; if (mon_q.size() !== 1) begin errors++; $display("FAIL flush_count: got %0d expected 1", mon_q.size()); end
    endtask

    task automatic test_backpressure();
        int idx;
        logic acc;
        mon_q.delete();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (idx < 8);
            in_data  = 8'(8'h41 + idx);
            acc      = in_ready && in_valid;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checks++; if (idx !== 8) begin errors++; $display("FAIL bp_accepted: got %0d expected 8", idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h44434241 || out_keep !== 4'hF) begin
            errors++; $display("FAIL bp_held_word: got %b %h %h expected 1 44434241 F", out_valid, out_data, out_keep); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h48474645) begin
            errors++; $display("FAIL bp_second_word: got %b %h expected 1 48474645", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_drained: got valid %b in_ready %b expected 0 1", out_valid, in_ready); end
        checks++; if (mon_q.size() !== 2) begin errors++; $display("FAIL bp_count: got %0d expected 2", mon_q.size()); end
        if (mon_q.size() == 2) begin
            checks++; if (mon_q[0] !== 36'hF_44434241) begin errors++; $display("FAIL bp_order0: got %h expected F44434241", mon_q[0]); end
            checks++; if (mon_q[1] !== 36'hF_48474645) begin errors++; $display("FAIL bp_order1: got %h expected F48474645", mon_q[1]); end
        end
    endtask

    task automatic test_flush_on_last();
        mon_q.delete();
        out_ready = 1'b1;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        flush = 1'b1;
        send_byte(8'hDD);
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hDDCCBBAA || out_keep !== 4'hF) begin
            errors++; $display("FAIL flast_word: got %b %h %h expected 1 DDCCBBAA F", out_valid, out_data, out_keep); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flast_in_ready: got %b expected 1", in_ready); end
        tick(); tick(); tick();
        checks++; if (mon_q.size() !== 1) begin errors++; $display("FAIL flast_count: got %0d expected 1", mon_q.size()); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty_state: got in_ready %b expected 1", in_ready); end
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || mon_q.size() !== 1) begin
            errors++; $display("FAIL flush_empty_out: got valid %b count %0d expected 0 1", out_valid, mon_q.size()); end
    endtask

    task automatic test_mid_reset();
        mon_q.delete();
        out_ready = 1'b1;
        send_byte(8'h55); send_byte(8'h66);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mrst_in_ready: got %b expected 0", in_ready); end
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b expected 0", out_valid); end
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA4A3A2A1 || out_keep !== 4'hF) begin
            errors++; $display("FAIL mrst_word: got %b %h %h expected 1 A4A3A2A1 F", out_valid, out_data, out_keep); end
        tick();
        checks++; if (mon_q.size() !== 1) begin errors++; $display("FAIL mrst_count: got %0d expected 1", mon_q.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_flush();
        test_backpressure();
        test_flush_on_last();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
